alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter XLEN, default 64, sets the operand and result width in bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  operands and op presented.
REQ-005 in_ready  out  1  block can accept a new operation.
REQ-006 opControl  in  4  ALU op code from the ALU control decoder.
REQ-007 a, b  in  XLEN each  operands (rs1, rs2/immediate).
REQ-008 out_valid  out  1  result registered and held.
REQ-009 out_ready  in  1  consumer takes the result.
REQ-010 result  out  XLEN  operation result.
REQ-011 zero  out  1  result == 0, for the branch decision.
REQ-012 illegal  out  1  op code unsupported; qualified by out_valid.

Function
REQ-013 The block SHALL implement the op codes AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111 (signed), NOR=1100, and MUL=1000 when enabled.
REQ-014 The block SHALL use three states: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL equal (state==IDLE); a transfer occurs when in_valid && in_ready.
REQ-016 Non-MUL transfer: the block SHALL register result/zero/illegal and go IDLE->DONE, with out_valid high on the next cycle (latency 1).
REQ-017 MUL transfer: the block SHALL go IDLE->BUSY and load a 6-bit iteration counter with 0.
REQ-018 BUSY: the block SHALL perform one shift-add step per cycle and go BUSY->DONE when the counter reaches 63; out_valid rises exactly 64 cycles after acceptance.
REQ-019 The MUL result SHALL be the low XLEN bits of a*b (the same for signed and unsigned operands).
REQ-020 DONE: result, zero and illegal SHALL hold stable while out_ready=0; out_valid && out_ready SHALL return the block to IDLE on that edge.
REQ-021 in_valid SHALL be ignored outside IDLE; a, b and opControl SHALL be sampled only at transfer.
REQ-022 ADD/SUB SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-023 SLT SHALL return 1 or 0, zero-extended.
REQ-024 An unknown op code (including 1111) SHALL take the 1-cycle path with result=0, zero=1, illegal=1.
REQ-025 out_valid and out_ready both high together with in_valid SHALL NOT accept a new op in the same cycle; sustained throughput is one op per 2 cycles.

Reset
REQ-026 rst_n low SHALL force, asynchronously, state=IDLE, counter=0, result=0, zero=0, illegal=0 and out_valid=0; in_ready=1 after release.
REQ-027 Reset asserted during BUSY or DONE SHALL abandon the operation; no partial result is ever presented.

Configuration
REQ-028 The macro ALU_EXEC_MUL_EN SHALL control whether MUL is compiled in.
REQ-029 With ALU_EXEC_MUL_EN defined: MUL behaves per REQ-017..019.
REQ-030 Without ALU_EXEC_MUL_EN: no BUSY logic or multiplier is instantiated, and 1000 is treated as unknown per REQ-024.

Structure
REQ-031 Package alu_pkg SHALL hold XLEN_DEFAULT, the op-code constants (enum alu_op_e) and the state enum exec_state_e; the ALU control decoder SHALL use the same op-code constants.
REQ-032 The iterative multiplier SHALL be a sub-module alu_mul_iter with ports start, a, b, done and product, instantiated only under ALU_EXEC_MUL_EN.

Verification
REQ-033 ADD a=5, b=7 with out_ready=1 -> out_valid one cycle after the transfer, result=12, zero=0, illegal=0.
REQ-034 SUB a=9, b=9, then SLT a=-1, b=1 -> result=0 with zero=1, then result=1 with zero=0.
REQ-035 MUL a=123456, b=-3 (MUL_EN defined) -> in_ready=0 for 64 cycles, then out_valid with result=-370368; without MUL_EN -> result=0, illegal=1 after 1 cycle.
REQ-036 opControl=1111 -> result=0, zero=1, illegal=1 at latency 1.
REQ-037 out_ready held low 10 cycles in DONE while in_valid=1 with new operands -> result unchanged and in_ready=0 throughout; IDLE follows the cycle out_ready rises.
REQ-038 rst_n pulsed low at iteration 30 of a MUL -> out_valid=0 and in_ready=1 after release; a following ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code and state definitions for the ALU execute stage.
// The ALU control decoder must use the same alu_op_e values.
package alu_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_MUL = 4'b1000,
        OP_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } exec_state_e;

    // Multiplier always runs 64 shift-add steps, independent of XLEN
    localparam logic [5:0] MUL_LAST_STEP = 6'd63;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle, 64 steps.
// product is the accumulator value after the current step; it is final while done is high.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    logic            busy_q, busy_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;

    // Only the low XLEN bits are kept, so signed and unsigned operands agree
    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == MUL_LAST_STEP);

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = product;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshake; single-cycle ops plus optional
// iterative MUL compiled in by defining ALU_EXEC_MUL_EN.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      opControl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    exec_state_e     state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] alu_res;
    logic            alu_illegal;
    logic            is_mul;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

`ifdef ALU_EXEC_MUL_EN
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign is_mul    = (opControl == OP_MUL);
    assign mul_start = in_ready && in_valid && is_mul;

    alu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (opControl)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  alu_res = ~(a | b);
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
                        state_d = ST_BUSY;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_illegal;
                        state_d   = ST_DONE;
                    end
                end
            end
`ifdef ALU_EXEC_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    result_d  = mul_product;
                    zero_d    = (mul_product == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
`endif
            // Returning to IDLE here means no new op can be taken on this edge
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
